// File: rtl/cache_axi_bridge_pkg.sv
// Shared state encodings, burst constants and address alignment for the cache-to-AXI bridge.
package cache_axi_bridge_pkg;

   typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rstate_e;
   typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wstate_e;

   localparam logic [2:0] LINE_TYPE = 3'b100;
   localparam logic [7:0] LINE_LEN  = 8'd3;
   localparam logic [7:0] WORD_LEN  = 8'd0;

   // Lines start on a 16-byte boundary, single words on a 4-byte boundary.
   function automatic logic [31:0] alignAddr(input logic [31:0] addr, input logic isLine);
      return isLine ? (addr & ~32'h0000_000F) : (addr & ~32'h0000_0003);
   endfunction

endpackage

// File: rtl/cache_axi_bridge.sv
// Bridges cache read/write requests onto AXI: independent read and write FSMs,
// with reads stalled while a write to the same line is still in flight.
module cache_axi_bridge
   import cache_axi_bridge_pkg::*;
(
   input  logic         clk,
   input  logic         resetn,
   input  logic         rd_req,
   input  logic [2:0]   rd_type,
   input  logic [31:0]  rd_addr,
   output logic         rd_rdy,
   output logic         ret_valid,
   output logic         ret_last,
   output logic [31:0]  ret_data,
   input  logic         wr_req,
   input  logic [2:0]   wr_type,
   input  logic [31:0]  wr_addr,
   input  logic [3:0]   wr_wstrb,
   input  logic [127:0] wr_data,
   output logic         wr_rdy,
   output logic         arvalid,
   input  logic         arready,
   output logic [31:0]  araddr,
   output logic [7:0]   arlen,
   input  logic         rvalid,
   input  logic [31:0]  rdata,
   input  logic         rlast,
   output logic         awvalid,
   input  logic         awready,
   output logic [31:0]  awaddr,
   output logic [7:0]   awlen,
   output logic         wvalid,
   input  logic         wready,
   output logic [31:0]  wdata,
   output logic [3:0]   wstrb,
   output logic         wlast,
   input  logic         bvalid
);

   rstate_e        rState_q, rState_d;
   logic [31:0]    araddr_q, araddr_d;
   logic [7:0]     arlen_q, arlen_d;

   wstate_e        wState_q, wState_d;
   logic [31:0]    awaddr_q, awaddr_d;
   logic [7:0]     awlen_q, awlen_d;
   logic [3:0]     wstrb_q, wstrb_d;
   logic [127:0]   wBuf_q, wBuf_d;
   logic [1:0]     beat_q, beat_d;

   logic           hit;
   logic           rdLine;
   logic           wrLine;
   logic           lastBeat;

   // A read may not overtake a write to the same line, whether it is in flight or being accepted now.
   assign hit = ((wState_q != W_IDLE) && (awaddr_q[31:4] == rd_addr[31:4]))
             || (wr_req && wr_rdy && (wr_addr[31:4] == rd_addr[31:4]));

   assign rdLine    = (rd_type == LINE_TYPE);
   assign wrLine    = (wr_type == LINE_TYPE);
   assign lastBeat  = (beat_q == awlen_q[1:0]);

   assign rd_rdy    = (rState_q == R_IDLE) && !hit;
   assign arvalid   = (rState_q == R_AR);
   assign araddr    = araddr_q;
   assign arlen     = arlen_q;
   assign ret_valid = (rState_q == R_DATA) && rvalid;
   assign ret_last  = (rState_q == R_DATA) && rlast;
   assign ret_data  = (rState_q == R_DATA) ? rdata : 32'h0;

   assign wr_rdy    = (wState_q == W_IDLE);
   assign awvalid   = (wState_q == W_AW);
   assign awaddr    = awaddr_q;
   assign awlen     = awlen_q;
   assign wvalid    = (wState_q == W_DATA);
   assign wdata     = wBuf_q[{beat_q, 5'b0} +: 32];
   assign wstrb     = wstrb_q;
   assign wlast     = wvalid && lastBeat;

   always_comb begin
      rState_d = rState_q;
      araddr_d = araddr_q;
      arlen_d  = arlen_q;
      case (rState_q)
         R_IDLE: begin
            if (rd_req && rd_rdy) begin
               rState_d = R_AR;
               araddr_d = alignAddr(rd_addr, rdLine);
               arlen_d  = rdLine ? LINE_LEN : WORD_LEN;
            end
         end
         R_AR:    if (arready) rState_d = R_DATA;
         R_DATA:  if (rvalid && rlast) rState_d = R_IDLE;
         default: rState_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rState_q <= R_IDLE;
         araddr_q <= 32'h0;
         arlen_q  <= 8'h0;
      end else begin
         rState_q <= rState_d;
         araddr_q <= araddr_d;
         arlen_q  <= arlen_d;
      end
   end

   // Beat counter only moves on a completed W handshake, so wdata holds through wready stalls.
   always_comb begin
      wState_d = wState_q;
      awaddr_d = awaddr_q;
      awlen_d  = awlen_q;
      wstrb_d  = wstrb_q;
      wBuf_d   = wBuf_q;
      beat_d   = beat_q;
      case (wState_q)
         W_IDLE: begin
            if (wr_req) begin
               wState_d = W_AW;
               wBuf_d   = wr_data;
               awaddr_d = alignAddr(wr_addr, wrLine);
               awlen_d  = wrLine ? LINE_LEN : WORD_LEN;
               wstrb_d  = wrLine ? 4'hF : wr_wstrb;
               beat_d   = 2'd0;
            end
         end
         W_AW: if (awready) wState_d = W_DATA;
         W_DATA: begin
            if (wready) begin
               if (lastBeat) begin
                  wState_d = W_RESP;
                  beat_d   = 2'd0;
               end else begin
                  beat_d   = beat_q + 2'd1;
               end
            end
         end
         W_RESP:  if (bvalid) wState_d = W_IDLE;
         default: wState_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wState_q <= W_IDLE;
         awaddr_q <= 32'h0;
         awlen_q  <= 8'h0;
         wstrb_q  <= 4'h0;
         wBuf_q   <= 128'h0;
         beat_q   <= 2'd0;
      end else begin
         wState_q <= wState_d;
         awaddr_q <= awaddr_d;
         awlen_q  <= awlen_d;
         wstrb_q  <= wstrb_d;
         wBuf_q   <= wBuf_d;
         beat_q   <= beat_d;
      end
   end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Self-checking bench for cache_axi_bridge: the bench plays the cache and the AXI slave,
// predicting every address, beat and handshake from a transaction-level model.
module tb_cache_axi_bridge;

   logic         clk = 1'b0;
   logic         resetn;
   logic         rd_req;
   logic [2:0]   rd_type;
   logic [31:0]  rd_addr;
   logic         rd_rdy;
   logic         ret_valid;
   logic         ret_last;
   logic [31:0]  ret_data;
   logic         wr_req;
   logic [2:0]   wr_type;
   logic [31:0]  wr_addr;
   logic [3:0]   wr_wstrb;
   logic [127:0] wr_data;
   logic         wr_rdy;
   logic         arvalid;
   logic         arready;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic         rvalid;
   logic [31:0]  rdata;
   logic         rlast;
   logic         awvalid;
   logic         awready;
   logic [31:0]  awaddr;
   logic [7:0]   awlen;
   logic         wvalid;
   logic         wready;
   logic [31:0]  wdata;
   logic [3:0]   wstrb;
   logic         wlast;
   logic         bvalid;

   int           nCompared   = 0;
   int           nMismatched = 0;

   // Model state: is a write outstanding on the bus, and which line does it target.
   bit           wrOutstanding = 1'b0;
   logic [31:0]  wrLineAddr    = 32'h0;

   cache_axi_bridge dut (
      .clk       (clk),
      .resetn    (resetn),
      .rd_req    (rd_req),
      .rd_type   (rd_type),
      .rd_addr   (rd_addr),
      .rd_rdy    (rd_rdy),
      .ret_valid (ret_valid),
      .ret_last  (ret_last),
      .ret_data  (ret_data),
      .wr_req    (wr_req),
      .wr_type   (wr_type),
      .wr_addr   (wr_addr),
      .wr_wstrb  (wr_wstrb),
      .wr_data   (wr_data),
      .wr_rdy    (wr_rdy),
      .arvalid   (arvalid),
      .arready   (arready),
      .araddr    (araddr),
      .arlen     (arlen),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .rlast     (rlast),
      .awvalid   (awvalid),
      .awready   (awready),
      .awaddr    (awaddr),
      .awlen     (awlen),
      .wvalid    (wvalid),
      .wready    (wready),
      .wdata     (wdata),
      .wstrb     (wstrb),
      .wlast     (wlast),
      .bvalid    (bvalid)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit rdBlocked(input logic [31:0] a);
      return wrOutstanding && (a[31:4] == wrLineAddr[31:4]);
   endfunction

   // One cache read, acting as the AXI read slave; data beats are dataBase, dataBase+1, ...
   task automatic doRead(input logic [31:0] addr, input bit isLine, input int arDelay,
                         input bit gaps, input logic [31:0] dataBase);
      logic [31:0] expAddr;
      logic [7:0]  expLen;
      logic [31:0] beatVal;
      bit          accepted;
      int          n;
      expAddr  = isLine ? {addr[31:4], 4'h0} : {addr[31:2], 2'b00};
      expLen   = isLine ? 8'd3 : 8'd0;
      n        = isLine ? 4 : 1;
      rd_req   = 1'b1;
      rd_addr  = addr;
      rd_type  = isLine ? 3'b100 : 3'($urandom_range(0, 3));
      accepted = 1'b0;
      for (int c = 0; c < 80 && !accepted; c++) begin
         #1;
         nCompared++;
         if (rd_rdy !== (rdBlocked(addr) ? 1'b0 : 1'b1)) begin
            nMismatched++;
            $display("[TB] FAIL rd_rdy_hazard addr=%h: got %b, expected %b", addr, rd_rdy, !rdBlocked(addr));
         end
         if (rd_rdy === 1'b1) accepted = 1'b1;
         tick();
      end
      rd_req = 1'b0;
      if (!accepted) begin
         nCompared++;
         nMismatched++;
         $display("[TB] FAIL rd_accept_timeout addr=%h: rd_rdy never rose", addr);
         return;
      end
      for (int c = 0; c <= arDelay; c++) begin
         arready = (c == arDelay);
         #1;
         nCompared++;
         if ({arvalid, araddr, arlen} !== {1'b1, expAddr, expLen}) begin
            nMismatched++;
            $display("[TB] FAIL ar_channel: got valid=%b addr=%h len=%0d, expected valid=1 addr=%h len=%0d",
                     arvalid, araddr, arlen, expAddr, expLen);
         end
         tick();
      end
      arready = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (gaps && ($urandom_range(0, 1) == 1)) begin
            rvalid = 1'b0;
            #1;
            nCompared++;
            if (ret_valid !== 1'b0) begin
               nMismatched++;
               $display("[TB] FAIL ret_gap: got ret_valid=%b, expected 0", ret_valid);
            end
            tick();
         end
         beatVal = dataBase + 32'(i);
         rvalid  = 1'b1;
         rdata   = beatVal;
         rlast   = (i == n - 1);
         #1;
         nCompared++;
         if ({ret_valid, ret_last, ret_data} !== {1'b1, (i == n - 1), beatVal}) begin
            nMismatched++;
            $display("[TB] FAIL ret_beat%0d: got valid=%b last=%b data=%h, expected valid=1 last=%b data=%h",
                     i, ret_valid, ret_last, ret_data, (i == n - 1), beatVal);
         end
         tick();
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      #1;
      nCompared++;
      if ({rd_rdy, arvalid, ret_valid} !== {(rdBlocked(addr) ? 1'b0 : 1'b1), 1'b0, 1'b0}) begin
         nMismatched++;
         $display("[TB] FAIL rd_done: got rd_rdy=%b arvalid=%b ret_valid=%b after last beat",
                  rd_rdy, arvalid, ret_valid);
      end
   endtask

   // One cache write, acting as the AXI write slave; toggle=1 alternates wready starting low.
   task automatic doWrite(input logic [31:0] addr, input bit isLine, input logic [127:0] data,
                          input logic [3:0] strb, input int awDelay, input bit toggle, input int bDelay);
      logic [31:0] expAddr;
      logic [7:0]  expLen;
      logic [3:0]  expStrb;
      logic [31:0] expWord;
      int          n;
      int          k;
      expAddr  = isLine ? {addr[31:4], 4'h0} : {addr[31:2], 2'b00};
      expLen   = isLine ? 8'd3 : 8'd0;
      expStrb  = isLine ? 4'hF : strb;
      n        = isLine ? 4 : 1;
      wr_req   = 1'b1;
      wr_addr  = addr;
      wr_type  = isLine ? 3'b100 : 3'($urandom_range(0, 3));
      wr_wstrb = strb;
      wr_data  = data;
      #1;
      nCompared++;
      if (wr_rdy !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL wr_rdy_idle: got %b, expected 1", wr_rdy);
         wr_req = 1'b0;
         return;
      end
      tick();
      wr_req        = 1'b0;
      wrOutstanding = 1'b1;
      wrLineAddr    = addr;
      for (int c = 0; c <= awDelay; c++) begin
         awready = (c == awDelay);
         #1;
         nCompared++;
         if ({awvalid, awaddr, awlen, wr_rdy} !== {1'b1, expAddr, expLen, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL aw_channel: got valid=%b addr=%h len=%0d wr_rdy=%b, expected valid=1 addr=%h len=%0d wr_rdy=0",
                     awvalid, awaddr, awlen, wr_rdy, expAddr, expLen);
         end
         tick();
      end
      awready = 1'b0;
      k = 0;
      for (int c = 0; c < 60 && k < n; c++) begin
         wready  = toggle ? c[0] : 1'($urandom_range(0, 1));
         expWord = data[32 * k +: 32];
         #1;
         nCompared++;
         if ({wvalid, wdata, wstrb, wlast} !== {1'b1, expWord, expStrb, (k == n - 1)}) begin
            nMismatched++;
            $display("[TB] FAIL w_beat%0d: got valid=%b data=%h strb=%h last=%b, expected valid=1 data=%h strb=%h last=%b",
                     k, wvalid, wdata, wstrb, wlast, expWord, expStrb, (k == n - 1));
         end
         if (wready) k++;
         tick();
      end
      wready = 1'b0;
      if (k < n) begin
         nCompared++;
         nMismatched++;
         $display("[TB] FAIL w_timeout: only %0d of %0d beats sent", k, n);
      end
      for (int c = 0; c <= bDelay; c++) begin
         bvalid = (c == bDelay);
         #1;
         nCompared++;
         if ({wvalid, wr_rdy} !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL w_resp_wait: got wvalid=%b wr_rdy=%b, expected 0 0", wvalid, wr_rdy);
         end
         tick();
      end
      bvalid        = 1'b0;
      wrOutstanding = 1'b0;
      #1;
      nCompared++;
      if (wr_rdy !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL wr_rdy_after_b: got %b, expected 1", wr_rdy);
      end
   endtask

   task automatic test_reset();
      resetn  = 1'b0;
      #3;
      nCompared++;
      if ({rd_rdy, wr_rdy, arvalid, awvalid, wvalid, wlast, ret_valid, ret_last} !== 8'b1100_0000) begin
         nMismatched++;
         $display("[TB] FAIL reset_ctrl: got rd_rdy=%b wr_rdy=%b arv=%b awv=%b wv=%b wl=%b rv=%b rl=%b",
                  rd_rdy, wr_rdy, arvalid, awvalid, wvalid, wlast, ret_valid, ret_last);
      end
      nCompared++;
      if ({araddr, arlen, awaddr, awlen, wdata, wstrb, ret_data} !== 148'h0) begin
         nMismatched++;
         $display("[TB] FAIL reset_data: got araddr=%h arlen=%h awaddr=%h awlen=%h wdata=%h wstrb=%h ret=%h, expected all 0",
                  araddr, arlen, awaddr, awlen, wdata, wstrb, ret_data);
      end
      @(negedge clk);
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_line_read();
      doRead(32'h1C00_0124, 1'b1, 2, 1'b0, 32'h0000_00A0);
      tick();
   endtask

   task automatic test_line_write();
      doWrite(32'h0000_1230, 1'b1, {32'h44, 32'h33, 32'h22, 32'h11}, 4'h0, 1, 1'b1, 2);
      tick();
   endtask

   task automatic test_word_write();
      doWrite(32'hBFAF_F002, 1'b0, {96'h0, 32'hDEAD_BEEF}, 4'b1100, 0, 1'b0, 1);
      tick();
   endtask

   task automatic test_raw_hazard();
      fork
         doWrite(32'h0000_1230, 1'b1, {32'h44, 32'h33, 32'h22, 32'h11}, 4'h0, 2, 1'b1, 3);
         begin
            repeat (3) tick();
            doRead(32'h0000_1238, 1'b0, 0, 1'b0, 32'h5500_0000);
         end
      join
      tick();
      fork
         doWrite(32'h0000_1230, 1'b1, {32'h44, 32'h33, 32'h22, 32'h11}, 4'h0, 2, 1'b1, 3);
         begin
            repeat (3) tick();
            doRead(32'h0000_2000, 1'b1, 1, 1'b0, 32'h6600_0000);
         end
      join
      tick();
   endtask

   task automatic test_back_to_back();
      fork
         doWrite(32'h0001_0040, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 4'h0, 0, 1'b0, 0);
         doRead(32'h0002_0080, 1'b1, 0, 1'b0, 32'h7700_0000);
      join
      tick();
   endtask

   task automatic test_random();
      for (int it = 0; it < 12; it++) begin
         automatic logic [31:0] wa = $urandom | 32'h0001_0000;
         automatic logic [31:0] ra = $urandom & ~32'h0001_0000;
         automatic int          rs = $urandom_range(0, 3);
         fork
            doWrite(wa, 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
                    4'($urandom_range(1, 15)), $urandom_range(0, 3), 1'b0, $urandom_range(0, 3));
            begin
               repeat (rs) tick();
               doRead(ra, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b1, $urandom);
            end
         join
         tick();
      end
   endtask

   task automatic test_reset_midread();
      rd_req  = 1'b1;
      rd_addr = 32'h0000_4000;
      rd_type = 3'b100;
      tick();
      rd_req  = 1'b0;
      arready = 1'b1;
      tick();
      arready = 1'b0;
      rvalid  = 1'b1;
      rdata   = 32'h0000_0001;
      rlast   = 1'b0;
      tick();
      rdata   = 32'h0000_0002;
      #1;
      nCompared++;
      if ({ret_valid, ret_data} !== {1'b1, 32'h0000_0002}) begin
         nMismatched++;
         $display("[TB] FAIL midread_beat2: got valid=%b data=%h, expected valid=1 data=00000002", ret_valid, ret_data);
      end
      resetn = 1'b0;
      #1;
      nCompared++;
      if ({arvalid, ret_valid, rd_rdy, wr_rdy} !== 4'b0011) begin
         nMismatched++;
         $display("[TB] FAIL midread_reset: got arvalid=%b ret_valid=%b rd_rdy=%b wr_rdy=%b, expected 0 0 1 1",
                  arvalid, ret_valid, rd_rdy, wr_rdy);
      end
      rvalid = 1'b0;
      rdata  = 32'h0;
      @(negedge clk);
      resetn = 1'b1;
      tick();
      #1;
      nCompared++;
      if ({arvalid, ret_valid, awvalid, wvalid, rd_rdy} !== 5'b00001) begin
         nMismatched++;
         $display("[TB] FAIL after_reset: got arvalid=%b ret_valid=%b awvalid=%b wvalid=%b rd_rdy=%b, expected 0 0 0 0 1",
                  arvalid, ret_valid, awvalid, wvalid, rd_rdy);
      end
   endtask

   initial begin
      resetn   = 1'b0;
      rd_req   = 1'b0;
      rd_type  = 3'b0;
      rd_addr  = 32'h0;
      wr_req   = 1'b0;
      wr_type  = 3'b0;
      wr_addr  = 32'h0;
      wr_wstrb = 4'h0;
      wr_data  = 128'h0;
      arready  = 1'b0;
      rvalid   = 1'b0;
      rdata    = 32'h0;
      rlast    = 1'b0;
      awready  = 1'b0;
      wready   = 1'b0;
      bvalid   = 1'b0;
      test_reset();
      test_line_read();
      test_line_write();
      test_word_write();
      test_raw_hazard();
      test_back_to_back();
      test_random();
      test_reset_midread();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/cache_axi_bridge.md
CACHE_AXI_BRIDGE -- requirements
Module: cache_axi_bridge

Interface
REQ-001 SHALL have no parameters; AXI fields not listed here (id=0, burst=INCR, size=3'b010, lock/cache/prot=0) and slave-side rready/bready (tied 1) are driven by the top wrapper.
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 resetn  in  1  reset, asynchronous assert, active-low.
REQ-004 rd_req  in  1  cache read request.
REQ-005 rd_type  in  3  3'b100 = line, other = single word.
REQ-006 rd_addr  in  32  read start address.
REQ-007 rd_rdy  out  1  read request accepted this cycle if rd_req=1.
REQ-008 ret_valid  out  1  read data beat valid.
REQ-009 ret_last  out  1  final beat of the read.
REQ-010 ret_data  out  32  read data beat.
REQ-011 wr_req  in  1  cache write request.
REQ-012 wr_type  in  3  3'b100 = line, other = single word.
REQ-013 wr_addr  in  32  write start address.
REQ-014 wr_wstrb  in  4  byte mask, single-word writes only.
REQ-015 wr_data  in  128  write data, word0 in [31:0].
REQ-016 wr_rdy  out  1  write request accepted this cycle if wr_req=1.
REQ-017 arvalid  out  1  AXI read address valid.
REQ-018 arready  in  1  AXI read address ready.
REQ-019 araddr  out  32  AXI read address.
REQ-020 arlen  out  8  beats-1.
REQ-021 rvalid  in  1  AXI read data valid.
REQ-022 rdata  in  32  AXI read data.
REQ-023 rlast  in  1  AXI last read beat.
REQ-024 awvalid  out  1  AXI write address valid.
REQ-025 awready  in  1  AXI write address ready.
REQ-026 awaddr  out  32  AXI write address.
REQ-027 awlen  out  8  beats-1.
REQ-028 wvalid  out  1  AXI write data valid.
REQ-029 wready  in  1  AXI write data ready.
REQ-030 wdata  out  32  AXI write data.
REQ-031 wstrb  out  4  AXI write strobe.
REQ-032 wlast  out  1  AXI last write beat.
REQ-033 bvalid  in  1  AXI write response valid.

Function
REQ-034 Read FSM states R_IDLE, R_AR, R_DATA:
- R_IDLE to R_AR on rd_req&rd_rdy.
- R_AR to R_DATA on arvalid&arready.
- R_DATA to R_IDLE on rvalid&rlast.
- arvalid=1 only in R_AR.
REQ-035 On read accept, capture:
- line: araddr={rd_addr[31:4],4'h0}, arlen=3.
- word: araddr={rd_addr[31:2],2'b00}, arlen=0.
- araddr and arlen held stable while arvalid=1.
REQ-036 In R_DATA: ret_valid=rvalid, ret_data=rdata, ret_last=rlast, combinational with zero latency. Outside R_DATA: ret_valid=0.
REQ-037 Write FSM states W_IDLE, W_AW, W_DATA, W_RESP:
- W_IDLE to W_AW on accept.
- W_AW to W_DATA on awready.
- W_DATA to W_RESP on wvalid&wready&wlast.
- W_RESP to W_IDLE on bvalid.
- wr_rdy = (state==W_IDLE).
REQ-038 On write accept, capture wr_data into a 128-bit buffer.
- Line write: awaddr={wr_addr[31:4],4'h0}, awlen=3, 4 beats from word0 upward, wstrb=4'hf.
- Word write: awaddr={wr_addr[31:2],2'b00}, awlen=0, one beat of wr_data[31:0] with wr_wstrb.
REQ-039 A 2-bit beat counter drives wdata. wlast=1 when count==awlen[1:0]. The beat advances only on wvalid&wready, and wdata is stable while stalled.
REQ-040 RAW hazard: rd_rdy = (read state==R_IDLE) & ~hit. hit is true when either:
- the write FSM is not W_IDLE and the buffered line address [31:4] equals rd_addr[31:4]; or
- wr_req&wr_rdy targets the same line in the same cycle.
REQ-041 Read and write to different lines SHALL proceed concurrently and independently. A same-cycle rd_req and wr_req to different lines SHALL both be accepted.

Reset
REQ-042 resetn low SHALL immediately force both FSMs idle, beat counter 0, and buffers 0. All outputs then read 0 except rd_rdy=1 and wr_rdy=1 (the reset value of arlen/awlen is 0). Reset mid-transaction SHALL abandon the transaction with no further AXI beats.

Structure
REQ-043 A shared package SHALL hold the FSM state encodings and constants: LINE_TYPE=3'b100, LINE_LEN=8'd3, WORD_LEN=8'd0.
REQ-044 The block SHALL be a single module with no sub-modules; the two FSMs SHALL be separate always blocks.

Verification
REQ-045 Line read of rd_addr=0x1C00_0124 with arready delayed 2 cycles SHALL produce araddr=0x1C00_0120 and arlen=3. Four rvalid beats 0xA0..0xA3 SHALL return on ret_data in order, with ret_last only on 0xA3 and rd_rdy back to 1 the next cycle.
REQ-046 Line write of wr_addr=0x0000_1230 with data words 0x11,0x22,0x33,0x44 and wready toggling SHALL produce awlen=3, wdata 0x11,0x22,0x33,0x44, wstrb=f, and wlast on 0x44. wr_rdy SHALL return to 1 only after bvalid.
REQ-047 Word write of wr_addr=0xBFAF_F002 with wstrb=4'b1100 SHALL produce awaddr=0xBFAF_F000, awlen=0, a single beat with wstrb=1100, and wlast=1.
REQ-048 With a write to line 0x0000_1230 pending and a read to 0x0000_1238, rd_rdy SHALL stay 0 until the cycle after bvalid. A read to 0x0000_2000 in the same situation SHALL be accepted immediately.
REQ-049 Asserting resetn=0 during beat 2 of a line read SHALL force arvalid=0, ret_valid=0, rd_rdy=1, and wr_rdy=1 with no clock edge needed.
